main_memory_refill: RTL and testbench

//  Backing main memory and line-refill engine sitting directly downstream of the direct-mapped cache.
//  - Accepts single-word write-through stores and line-fill read requests on a valid/ready port.
//  - Serves each fill after a fixed access latency and a 4-beat 32-bit internal burst.
//  - Returns a 128-bit line plus its line-aligned address, ready to load into a cache block.

---
 rtl/main_memory_refill_pkg.sv | 20 ++
 rtl/main_memory_refill_if.sv | 28 ++
 rtl/main_memory_refill_mem_word_array.sv | 23 ++
 rtl/main_memory_refill.sv | 173 +++++++++++++++++
 tb/tb_main_memory_refill.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/main_memory_refill_pkg.sv
// Shared types and constants for the main-memory refill engine.
package main_mem_pkg;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_W       = 2;
  localparam int unsigned LINE_W         = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Clears the word-offset bits so the address points at word 0 of its line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'(WORDS_PER_LINE - 1);
  endfunction

endpackage

// File: rtl/main_memory_refill_if.sv
// Request/fill port between the cache (master) and the refill engine (slave).
interface main_memory_refill_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned WORD_W = 32
);
  import main_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, fill_valid, fill_addr, fill_data, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, fill_valid, fill_addr, fill_data, busy
  );

endinterface

// File: rtl/main_memory_refill_mem_word_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module mem_word_array #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o_c = mem_q[addr_i];

endmodule

// File: rtl/main_memory_refill.sv
// Backing memory plus line-refill FSM (IDLE/WAIT/BURST/RESP).
// Optional MAIN_MEM_LINE_BUF_EN adds a one-line buffer of the last returned line.
module main_memory_refill
  import main_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  main_memory_refill_if.slave  bus
);

  localparam int unsigned LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              ready_q, ready_d;
  logic              busy_q;
  logic              fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0] fill_data_q, fill_data_d;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [WORD_W-1:0] mem_rdata_c;
  logic [ADDR_W-1:0] req_line_c;

`ifdef MAIN_MEM_LINE_BUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [LINE_W-1:0] buf_data_q, buf_data_d;
  logic              buf_hit_c;
`endif

  mem_word_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk       (clock),
    .we_i      (mem_we_c),
    .addr_i    (mem_addr_c),
    .wdata_i   (bus.req_wdata),
    .rdata_o_c (mem_rdata_c)
  );

  assign req_line_c = ADDR_W'(line_align(32'(bus.req_addr)));

`ifdef MAIN_MEM_LINE_BUF_EN
  assign buf_hit_c = buf_valid_q && (buf_addr_q == req_line_c);
`endif

  // Next-state, storage-port arbitration and output staging.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    base_d       = base_q;
    line_d       = line_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    mem_we_c     = 1'b0;
    mem_addr_c   = {base_q[ADDR_W-1:OFFSET_W], beat_q};
`ifdef MAIN_MEM_LINE_BUF_EN
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
`endif

    unique case (state_q)
      IDLE: begin
        mem_addr_c = bus.req_addr;
        if (bus.req_valid) begin
          if (bus.req_write) begin
            mem_we_c = 1'b1;
`ifdef MAIN_MEM_LINE_BUF_EN
            if (buf_hit_c)
              buf_data_d[32'(bus.req_addr[OFFSET_W-1:0]) * WORD_W +: WORD_W] = bus.req_wdata;
`endif
          end else begin
            base_d = req_line_c;
            beat_d = 2'd0;
            lat_d  = '0;
            state_d = (LATENCY == 0) ? BURST : WAIT;
`ifdef MAIN_MEM_LINE_BUF_EN
            // Buffered line: skip the storage access entirely.
            if (buf_hit_c) begin
              state_d      = RESP;
              fill_valid_d = 1'b1;
              fill_addr_d  = req_line_c;
              fill_data_d  = buf_data_q;
            end
`endif
          end
        end
      end
      WAIT: begin
        if (lat_q == LAT_W'(LATENCY - 1)) state_d = BURST;
        else                              lat_d   = lat_q + LAT_W'(1);
      end
      BURST: begin
        line_d[32'(beat_q) * WORD_W +: WORD_W] = mem_rdata_c;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d      = RESP;
          fill_valid_d = 1'b1;
          fill_addr_d  = base_q;
          fill_data_d  = line_d;
`ifdef MAIN_MEM_LINE_BUF_EN
          buf_valid_d  = 1'b1;
          buf_addr_d   = base_q;
          buf_data_d   = line_d;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers; storage contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      beat_q       <= '0;
      base_q       <= '0;
      line_q       <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
`ifdef MAIN_MEM_LINE_BUF_EN
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      line_q       <= line_d;
      ready_q      <= ready_d;
      busy_q       <= ~ready_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
`ifdef MAIN_MEM_LINE_BUF_EN
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
`endif
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_data  = fill_data_q;

endmodule

// File: tb/tb_main_memory_refill.sv
// Directed bench: LATENCY=4 instance (dut_a) and LATENCY=0 instance (dut_b).
module tb_main_memory_refill;

  localparam int HIT_CYC =
`ifdef MAIN_MEM_LINE_BUF_EN
    1;
`else
    9;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [14:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  int          tgt = 0;

  logic         o_ready, o_busy, o_valid;
  logic [14:0]  o_addr;
  logic [127:0] o_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  main_memory_refill_if #(.ADDR_W(15), .WORD_W(32)) bus_a ();
  main_memory_refill_if #(.ADDR_W(15), .WORD_W(32)) bus_b ();

  assign bus_a.req_valid = req_valid && (tgt == 0);
  assign bus_a.req_write = req_write;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_b.req_valid = req_valid && (tgt == 1);
  assign bus_b.req_write = req_write;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_wdata = req_wdata;

  main_memory_refill #(.ADDR_W(15), .WORD_W(32), .LATENCY(4)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a.slave));
  main_memory_refill #(.ADDR_W(15), .WORD_W(32), .LATENCY(0)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b.slave));

  always_comb begin
    if (tgt == 0) begin
      o_ready = bus_a.req_ready; o_busy = bus_a.busy; o_valid = bus_a.fill_valid;
      o_addr  = bus_a.fill_addr; o_data = bus_a.fill_data;
    end else begin
      o_ready = bus_b.req_ready; o_busy = bus_b.busy; o_valid = bus_b.fill_valid;
      o_addr  = bus_b.fill_addr; o_data = bus_b.fill_data;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic do_store(input logic [14:0] addr, input logic [31:0] data);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
  endtask

  // Issues a fill and returns the cycle (edge 0 = acceptance) fill_valid is seen; 0 on timeout.
  task automatic do_fill(input logic [14:0] addr, output int cyc);
    cyc = 0;
    @(negedge clock);
    check("fill_ready_before", 128'(o_ready), 128'(1));
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (o_valid) begin cyc = k; break; end
    end
  endtask

  initial begin
    int cyc;
    int low;
    int pulses;
    logic fv9;
    logic [127:0] d;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 128'(o_ready), 128'(1));
    check("rst_busy",  128'(o_busy),  128'(0));
    check("rst_fv",    128'(o_valid), 128'(0));
    check("rst_faddr", 128'(o_addr),  128'(0));
    check("rst_fdata", o_data,        128'(0));

    // Back-to-back stores, then a fill of the same line.
    do_store(15'h0010, 32'h11111111);
    do_store(15'h0011, 32'h22222222);
    check("store_ready", 128'(o_ready), 128'(1));
    do_store(15'h0012, 32'h33333333);
    do_store(15'h0013, 32'h44444444);
    do_fill(15'h0012, cyc);
    check("t1_cycle", 128'(cyc), 128'(9));
    check("t1_addr",  128'(o_addr), 128'(15'h0010));
    check("t1_data",  o_data, 128'h44444444_33333333_22222222_11111111);

    // Idle: fill outputs hold, no pulse.
    repeat (3) @(negedge clock);
    check("idle_fv",    128'(o_valid), 128'(0));
    check("idle_ready", 128'(o_ready), 128'(1));
    check("idle_addr",  128'(o_addr),  128'(15'h0010));
    check("idle_data",  o_data, 128'h44444444_33333333_22222222_11111111);

    // Zero-latency instance, top line of the address space.
    tgt = 1;
    do_store(15'h0000, 32'h99999999);
    do_store(15'h7FFC, 32'hC0000000);
    do_store(15'h7FFD, 32'hC0000001);
    do_store(15'h7FFE, 32'hC0000002);
    do_store(15'h7FFF, 32'hC0000003);
    do_fill(15'h7FFF, cyc);
    check("t4_cycle", 128'(cyc), 128'(5));
    check("t4_addr",  128'(o_addr), 128'(15'h7FFC));
    check("t4_data",  o_data, 128'hC0000003_C0000002_C0000001_C0000000);
    tgt = 0;

    // Requester holds req_valid through a busy period.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0020;
    low = 0; fv9 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 1) req_addr = 15'h0010;
      if (!o_ready) low++;
      if (k == 9) fv9 = o_valid;
    end
    check("t2_ready_low", 128'(low), 128'(9));
    check("t2_fv9",       128'(fv9), 128'(1));
    @(negedge clock);
    check("t2_ready_c10", 128'(o_ready), 128'(1));
    cyc = 0;
    for (int k = 11; k <= 60; k++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (k == 11) check("t2_accepted", 128'(o_ready), 128'(0));
      if (o_valid) begin cyc = k; break; end
    end
    check("t2_second_cycle", 128'(cyc), 128'(19));
    check("t2_second_data",  o_data, 128'h44444444_33333333_22222222_11111111);

    // Reset during BURST aborts the fill.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0040;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (k == 6) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    check("t3_ready", 128'(o_ready), 128'(1));
    check("t3_fv",    128'(o_valid), 128'(0));
    check("t3_addr",  128'(o_addr),  128'(0));
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (o_valid) pulses++;
    end
    check("t3_no_pulse", 128'(pulses), 128'(0));
    do_fill(15'h0011, cyc);
    check("t3_fresh_cycle", 128'(cyc), 128'(9));
    check("t3_fresh_data",  o_data, 128'h44444444_33333333_22222222_11111111);

    // Refill of the most recent line, then a store into it.
    do_fill(15'h0013, cyc);
    check("t5_refill_cycle", 128'(cyc), 128'(HIT_CYC));
    check("t5_refill_addr",  128'(o_addr), 128'(15'h0010));
    do_store(15'h0011, 32'hDEADBEEF);
    do_fill(15'h0010, cyc);
    d = o_data;
    check("t5_store_cycle", 128'(cyc), 128'(HIT_CYC));
    check("t5_word1", 128'(d[63:32]), 128'(32'hDEADBEEF));

    // Store immediately followed by a fill of the same word.
    do_store(15'h0013, 32'h55555555);
    do_fill(15'h0013, cyc);
    check("t6_cycle", 128'(cyc), 128'(HIT_CYC));
    check("t6_data",  o_data, 128'h55555555_33333333_DEADBEEF_11111111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
